mult_accum: RTL and testbench
=============================

// Module: mult_accum
// PURPOSE
//  Downstream consumer of the 4x4 array multiplier. Accepts 8-bit products over a
//  valid/ready handshake, sums COUNT of them into one accumulated result, then
//  presents that result on a second valid/ready handshake.
//  Forms the sequential back end of a dot-product / MAC datapath; the parent
//  instantiates the combinational multiplier and wires its P to p.
// PARAMETERS
//  COUNT  4   products summed per result; legal range 2..255
//  ACC_W  16  accumulator / result width; must be >= 8
//  CNT_W  8   beat-counter width; must satisfy 2**CNT_W > COUNT
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  p         in   8      unsigned product from multiplier
//  p_valid   in   1      p is valid this cycle
//  p_ready   out  1      block accepts p this cycle
//  clear     in   1      synchronous abort: discard partial sum
//  acc_out   out  ACC_W  accumulated result
//  acc_valid out  1      acc_out holds a completed result
//  acc_ready in   1      consumer takes acc_out
//  acc_ovf   out  1      sticky: current sum exceeded 2**ACC_W-1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, acc_out=0, cnt=0, acc_valid=0, acc_ovf=0.
//   p_ready=1 (combinational from state). Reset overrides everything at any point,
//   including mid-ACCUM or HOLD.
//  Beat: a product is taken only when p_valid && p_ready at the clk edge.
//   acc_out <= acc_out + {0,p}; cnt <= cnt+1.
//  FSM:
//   IDLE  : cnt=0, p_ready=1. On a beat -> ACCUM (-> HOLD directly only if COUNT==1; not legal).
//   ACCUM : p_ready=1. On the beat with cnt==COUNT-1 -> HOLD. Otherwise stay.
//   HOLD  : p_ready=0, acc_valid=1, acc_out and acc_ovf held stable.
//           On acc_valid && acc_ready: acc_out<=0, cnt<=0, acc_ovf<=0 -> IDLE.
//  Latency: acc_valid rises the cycle after the COUNT-th beat.
//   There is one bubble after the result handoff: p_ready returns to 1 the cycle after it.
//  Backpressure: p_valid/p are ignored while in HOLD. acc_out must not change until
//   it is accepted.
//  clear: synchronous; priority below reset, above beats and handoff, in every state.
//   acc_out<=0, cnt<=0, acc_ovf<=0, state<=IDLE. A pending result in HOLD is dropped.
//   A beat coinciding with clear is discarded.
//  Width: p is zero-extended to ACC_W+1. Carry out of bit ACC_W-1 constitutes overflow.
//   With ACC_W >= 8+clog2(COUNT) overflow is impossible.
// CONFIGURATION
//  MULT_ACCUM_SAT_EN defined:
//   on overflow, acc_out clamps to {ACC_W{1'b1}} and stays there for the rest of the set.
//   acc_ovf<=1.
//  Undefined: sum wraps modulo 2**ACC_W and acc_ovf<=1 (sticky until handoff, clear or reset).
// STRUCTURE
//  mult_accum_pkg: PROD_W=8 constant; state_t enum {IDLE,ACCUM,HOLD}.
//  No sub-module. Counter, adder and FSM stay in one always_ff plus a combinational next-state block.
//  The multiplier stays outside this block and is instantiated by the parent.
// TESTING
//  1 reset: hold rst_n=0 mid-operation -> acc_out=0, acc_valid=0, acc_ovf=0, p_ready=1
//    immediately (asynchronous).
//  2 basic: four beats p=225 (15x15), acc_ready=1 -> acc_valid=1 one cycle after
//    the 4th beat, acc_out=900 (0x0384). IDLE one cycle later.
//  3 backpressure: complete a set with acc_ready=0 for 5 cycles and p_valid=1 throughout
//    -> p_ready=0, acc_out stable. Raise ready, then beats 1,2,3,4 -> acc_out=10.
//  4 clear: two beats of 50, pulse clear, then four beats of 10 -> acc_out=40, acc_ovf=0.
//    Clear in HOLD -> acc_valid drops next cycle.
//  5 overflow (ACC_W=9, COUNT=4): four beats of 225 -> no macro: acc_out=388, acc_ovf=1.
//    MULT_ACCUM_SAT_EN: acc_out=511, acc_ovf=1.
//  6 throughput: p_valid held high, acc_ready high -> one result every COUNT+1 cycles.
//    Sums match the reference model across 1000 random products.

Source files
------------

// File: rtl/mult_accum_pkg.sv
// mult_accum_pkg
//   Shared constants and types for the multiply-accumulate back end.
//   PROD_W  : width of the unsigned product arriving from the 4x4 multiplier
//   state_t : accumulator sequencing states (IDLE / ACCUM / HOLD)
package mult_accum_pkg;

  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_accum.sv
// mult_accum
//   Sums COUNT unsigned 8-bit products taken over a valid/ready handshake and
//   presents the total on a second valid/ready handshake. Sequential back end of
//   a dot-product / MAC datapath; the multiplier itself lives in the parent.
//
//   Build option: define MULT_ACCUM_SAT_EN to saturate the sum at all-ones on
//   overflow; otherwise the sum wraps modulo 2**ACC_W. acc_ovf flags overflow
//   in both builds and stays set until handoff, clear or reset.
//
//   Parameters
//     COUNT  products per result, 2..255
//     ACC_W  accumulator width, >= 8
//     CNT_W  beat counter width, 2**CNT_W > COUNT
//
//   Ports
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     p          in   product from multiplier
//     p_valid    in   p is valid
//     p_ready    out  block accepts p this cycle
//     clear      in   synchronous abort, discards partial or pending result
//     acc_out    out  accumulated result
//     acc_valid  out  acc_out holds a completed result
//     acc_ready  in   consumer takes acc_out
//     acc_ovf    out  sticky overflow of the current sum
//
//   state | meaning
//   IDLE  | no beats taken yet for this set, counter at zero
//   ACCUM | at least one beat taken, waiting for the rest of the set
//   HOLD  | result complete, acc_out frozen until the consumer takes it
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] p,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              acc_ovf
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic               w_beat;
  logic               w_handoff;
  logic               w_last_beat;
  logic [ACC_W:0]     w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_nxt;

  assign w_beat      = p_valid && p_ready;
  assign w_handoff   = acc_valid && acc_ready;
  assign w_last_beat = w_beat && (r_cnt == CNT_W'(COUNT - 1));

  // One extra bit of headroom so the carry out of the top accumulator bit is
  // visible as overflow.
  assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
  assign w_carry = w_sum[ACC_W];

`ifdef MULT_ACCUM_SAT_EN
  // Once saturated, stay pinned for the rest of the set even if later
  // products are zero and would not themselves carry.
  assign w_acc_nxt = (r_ovf || w_carry) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

  // State register and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (clear) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_beat) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        r_ovf <= r_ovf | w_carry;
      end else if (w_handoff) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  // Next-state logic; clear outranks beats and handoff in every state
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_last_beat)  w_state_nxt = HOLD;
          else if (w_beat)  w_state_nxt = ACCUM;
        end
        ACCUM: begin
          if (w_last_beat)  w_state_nxt = HOLD;
        end
        HOLD: begin
          if (w_handoff)    w_state_nxt = IDLE;
        end
        default:            w_state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from state only
  always_comb begin
    p_ready   = 1'b1;
    acc_valid = 1'b0;
    case (r_state)
      HOLD: begin
        p_ready   = 1'b0;
        acc_valid = 1'b1;
      end
      default: begin
        p_ready   = 1'b1;
        acc_valid = 1'b0;
      end
    endcase
  end

  assign acc_out = r_acc;
  assign acc_ovf = r_ovf;

endmodule

// File: tb/tb_mult_accum.sv
// tb_mult_accum
//   Drives two mult_accum instances (ACC_W=16 and ACC_W=9, both COUNT=4) with
//   identical stimulus. A sum-level reference model predicts every output on
//   every cycle; directed sequences add hand-computed literal expectations.
//   Define MULT_ACCUM_SAT_EN for the saturating build.
module tb_mult_accum;

  localparam int COUNT = 4;
  localparam int WA    = 16;
  localparam int WB    = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    p;
  logic          p_valid;
  logic          clear;
  logic          acc_ready;

  logic          a_p_ready, a_acc_valid, a_acc_ovf;
  logic [WA-1:0] a_acc_out;
  logic          b_p_ready, b_acc_valid, b_acc_ovf;
  logic [WB-1:0] b_acc_out;

  int n_vec = 0;
  int n_err = 0;

  mult_accum #(.COUNT(COUNT), .ACC_W(WA), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .p(p), .p_valid(p_valid), .p_ready(a_p_ready),
    .clear(clear), .acc_out(a_acc_out), .acc_valid(a_acc_valid),
    .acc_ready(acc_ready), .acc_ovf(a_acc_ovf)
  );

  mult_accum #(.COUNT(COUNT), .ACC_W(WB), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .p(p), .p_valid(p_valid), .p_ready(b_p_ready),
    .clear(clear), .acc_out(b_acc_out), .acc_valid(b_acc_valid),
    .acc_ready(acc_ready), .acc_ovf(b_acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the running sum of accepted products as a plain integer,
  // the number of products in the current set, and whether a finished result
  // is waiting for the consumer.
  bit m_hold = 1'b0;
  int m_n    = 0;
  int m_sum  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold <= 1'b0;
      m_n    <= 0;
      m_sum  <= 0;
    end else if (clear) begin
      m_hold <= 1'b0;
      m_n    <= 0;
      m_sum  <= 0;
    end else if (m_hold) begin
      if (acc_ready) begin
        m_hold <= 1'b0;
        m_n    <= 0;
        m_sum  <= 0;
      end
    end else if (p_valid) begin
      m_sum <= m_sum + int'(p);
      m_n   <= m_n + 1;
      if (m_n + 1 == COUNT) m_hold <= 1'b1;
    end
  end

  function automatic int exp_acc(input int s, input int w);
    int mx;
    mx = (1 << w) - 1;
    if (s <= mx) return s;
`ifdef MULT_ACCUM_SAT_EN
    return mx;
`else
    return s % (1 << w);
`endif
  endfunction

  function automatic bit exp_ovf(input int s, input int w);
    return s > ((1 << w) - 1);
  endfunction

  always @(negedge clk) begin
    check("a_p_ready",   a_p_ready,   !m_hold);
    check("a_acc_valid", a_acc_valid, m_hold);
    check("a_acc_out",   a_acc_out,   exp_acc(m_sum, WA));
    check("a_acc_ovf",   a_acc_ovf,   exp_ovf(m_sum, WA));
    check("b_p_ready",   b_p_ready,   !m_hold);
    check("b_acc_valid", b_acc_valid, m_hold);
    check("b_acc_out",   b_acc_out,   exp_acc(m_sum, WB));
    check("b_acc_ovf",   b_acc_ovf,   exp_ovf(m_sum, WB));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int last_rise;
    int n_rise;
    bit prev_v;
    logic [WA-1:0] held;

    rst_n = 1'b0; p = '0; p_valid = 1'b0; clear = 1'b0; acc_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_p_ready", a_p_ready, 1);
    check("rst_acc_out", a_acc_out, 0);
    check("rst_acc_valid", a_acc_valid, 0);

    // Basic: four beats of 225 -> 900; 9-bit instance overflows
    acc_ready = 1'b1; p_valid = 1'b1; p = 8'd225;
    repeat (3) tick();
    check("basic_valid_early", a_acc_valid, 0);
    tick();
    p_valid = 1'b0;
    check("basic_valid", a_acc_valid, 1);
    check("basic_sum", a_acc_out, 900);
    check("basic_ready_low", a_p_ready, 0);
`ifdef MULT_ACCUM_SAT_EN
    check("ovf9_sum", b_acc_out, 511);
`else
    check("ovf9_sum", b_acc_out, 388);
`endif
    check("ovf9_flag", b_acc_ovf, 1);
    check("ovf16_flag", a_acc_ovf, 0);
    tick();
    check("basic_idle_valid", a_acc_valid, 0);
    check("basic_idle_ready", a_p_ready, 1);
    check("basic_idle_sum", a_acc_out, 0);

    // Backpressure: result held with p_valid high and junk on p
    acc_ready = 1'b0; p_valid = 1'b1; p = 8'd7;
    repeat (4) tick();
    held = a_acc_out;
    check("bp_sum", held, 28);
    for (int i = 0; i < 5; i++) begin
      p = 8'($urandom_range(0, 255));
      tick();
      check("bp_ready", a_p_ready, 0);
      check("bp_stable", a_acc_out, held);
    end
    acc_ready = 1'b1;
    tick();
    check("bp_bubble_done", a_p_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      p = 8'(i);
      tick();
    end
    p_valid = 1'b0;
    check("bp_sum_1234", a_acc_out, 10);
    tick();

    // Clear: partial sum and coinciding beat discarded
    acc_ready = 1'b0; p_valid = 1'b1; p = 8'd50;
    repeat (2) tick();
    clear = 1'b1; p = 8'd99;
    tick();
    clear = 1'b0; p = 8'd10;
    repeat (4) tick();
    p_valid = 1'b0;
    check("clr_sum", a_acc_out, 40);
    check("clr_ovf", a_acc_ovf, 0);
    check("clr_valid", a_acc_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_hold_drop", a_acc_valid, 0);
    check("clr_hold_sum", a_acc_out, 0);

    // Throughput: one result every COUNT+1 cycles over 1000 products
    acc_ready = 1'b1; p_valid = 1'b1;
    prev_v = 1'b0; last_rise = -1; n_rise = 0;
    for (int cyc = 0; cyc < 1250; cyc++) begin
      p = 8'($urandom_range(0, 255));
      tick();
      if (a_acc_valid && !prev_v) begin
        if (last_rise >= 0) check("tput_period", cyc - last_rise, COUNT + 1);
        last_rise = cyc;
        n_rise++;
      end
      prev_v = a_acc_valid;
    end
    check("tput_results", n_rise, 250);

    // Random handshakes with occasional clear, then asynchronous reset mid-set
    for (int cyc = 0; cyc < 2000; cyc++) begin
      p_valid   = ($urandom_range(0, 3) != 0);
      p         = 8'($urandom_range(0, 255));
      acc_ready = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 31) == 0);
      tick();
    end
    clear = 1'b0; acc_ready = 1'b0; p_valid = 1'b1; p = 8'd200;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc_out", a_acc_out, 0);
    check("arst_acc_valid", a_acc_valid, 0);
    check("arst_acc_ovf", b_acc_ovf, 0);
    check("arst_p_ready", a_p_ready, 1);
    tick();
    rst_n = 1'b1;
    p_valid = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
